// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the round-robin data-RAM arbiter.
// Optional build macro used by the top: RAM_RR_ARB_PRIORITY0_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEFAULT_N       = 3;
  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_AW      = 32;
  localparam int DEFAULT_TIMEOUT = 64;

  // Index of the set bit in a one-hot vector of up to 8 requesters; 0 when empty.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_rr_arb_pick.sv
// rr_pick: combinational rotating priority encoder. Scans from last+1 upward
// with wrap; with PRIORITY0 set, requester 0 wins outright and is skipped by the scan.
module rr_pick #(
  parameter int N         = 3,
  parameter bit PRIORITY0 = 1'b0
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] win,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  int cand;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    cand  = 0;
    if (PRIORITY0 && req[0]) begin
      valid = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = (int'(last) + k) % N;
        if (!valid && req[cand] && !(PRIORITY0 && cand == 0)) begin
          valid = 1'b1;
          win   = IW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/ram_rr_arb.sv
// ram_rr_arb: N-requester Wishbone-classic round-robin arbiter for the shared
// single-port data RAM, with per-transaction timeout. Macro: RAM_RR_ARB_PRIORITY0_EN.
module ram_rr_arb
  import ram_arb_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int AW      = DEFAULT_AW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic [N-1:0]       m_cyc,
  input  logic [N-1:0]       m_we,
  input  logic [4*N-1:0]     m_sel,
  input  logic [AW*N-1:0]    m_adr,
  input  logic [WIDTH*N-1:0] m_dat,
  output logic [N-1:0]       m_ack,
  output logic [WIDTH*N-1:0] m_rdt,
  output logic               x_cyc,
  output logic               x_we,
  output logic [3:0]         x_sel,
  output logic [AW-1:0]      x_adr,
  output logic [WIDTH-1:0]   x_dat,
  input  logic               x_ack,
  input  logic [WIDTH-1:0]   x_rdt,
  output logic [N-1:0]       grant,
  output logic               busy,
  output logic               timeout
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

`ifdef RAM_RR_ARB_PRIORITY0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] win, own;
  logic          win_valid, in_busy, own_cyc, forced;

  rr_pick #(.N(N), .PRIORITY0(PRIO0)) u_pick (
    .req  (m_cyc),
    .last (last_q),
    .win  (win),
    .valid(win_valid)
  );

  assign in_busy = (state_q == BUSY);
  assign own     = IW'(onehot_to_index(8'(grant_q)));
  assign own_cyc = in_busy && m_cyc[own];
  assign forced  = own_cyc && !x_ack && (cnt_q == CW'(TIMEOUT - 1));

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign timeout = forced;

  // Handshake: a requester holds m_cyc with stable we/sel/adr/dat until it sees
  // m_ack for one cycle; dropping m_cyc before that abandons the transaction.
  always_comb begin
    x_cyc = 1'b0;
    x_we  = 1'b0;
    x_sel = '0;
    x_adr = '0;
    x_dat = '0;
    m_ack = '0;
    m_rdt = '0;
    if (in_busy) begin
      x_cyc      = m_cyc[own];
      x_we       = m_we[own];
      x_sel      = m_sel[own*4 +: 4];
      x_adr      = m_adr[own*AW +: AW];
      x_dat      = m_dat[own*WIDTH +: WIDTH];
      m_ack[own] = own_cyc && (x_ack || forced);
      if (!forced) m_rdt[own*WIDTH +: WIDTH] = x_rdt;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d      = BUSY;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          cnt_d        = '0;
          // Priority-0 grants leave the rotation pointer for the others untouched.
          if (!(PRIO0 && win == '0)) last_d = win;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (x_ack || forced) begin
          state_d = GAP;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_rr_arb.sv
// Bench for ram_rr_arb: per-cycle transaction-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_ram_rr_arb;

  localparam int N = 3, WIDTH = 32, AW = 32, TIMEOUT = 64;
`ifdef RAM_RR_ARB_PRIORITY0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic               wb_clk = 1'b0;
  logic               wb_rst;
  logic [N-1:0]       m_cyc, m_we, m_ack;
  logic [4*N-1:0]     m_sel;
  logic [AW*N-1:0]    m_adr;
  logic [WIDTH*N-1:0] m_dat, m_rdt;
  logic               x_cyc, x_we, x_ack;
  logic [3:0]         x_sel;
  logic [AW-1:0]      x_adr;
  logic [WIDTH-1:0]   x_dat, x_rdt;
  logic [N-1:0]       grant;
  logic               busy, timeout;

  ram_rr_arb #(.N(N), .WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat),
    .m_ack(m_ack), .m_rdt(m_rdt),
    .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat),
    .x_ack(x_ack), .x_rdt(x_rdt),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk = ~wb_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, failures = 0;
  logic [N-1:0] exp_q[$];

  // model: phase 0 = idle, 1 = serving owner, 2 = dead cycle
  int ph, own, lst, age;
  int ram_lat, ram_wait, lat_max, never_pct, stray_pct;
  bit ram_never;
  logic [31:0] mem [16];
  logic [N-1:0] ack_seen;

  logic               s_xcyc, s_xwe, s_busy, s_timeout;
  logic [3:0]         s_xsel;
  logic [AW-1:0]      s_xadr;
  logic [WIDTH-1:0]   s_xdat;
  logic [N-1:0]       s_mack, s_grant;
  logic [WIDTH*N-1:0] s_mrdt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int last);
    if (PRIO && req[0]) return 0;
    for (int o = 1; o <= N; o++) begin
      int c = (last + o) % N;
      if (req[c] && !(PRIO && c == 0)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ph = 0; own = 0; lst = N - 1; age = 0;
    ram_wait = 0; ram_lat = 0; ram_never = 1'b0; ack_seen = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit cyc, input bit we, input logic [3:0] sel,
                         input logic [AW-1:0] adr, input logic [WIDTH-1:0] dat);
    m_cyc[i] = cyc;
    m_we[i] = we;
    m_sel[i*4 +: 4] = sel;
    m_adr[i*AW +: AW] = adr;
    m_dat[i*WIDTH +: WIDTH] = dat;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    m_cyc = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    x_ack = 1'b0; x_rdt = '0;
    lat_max = 0; never_pct = 0; stray_pct = 0;
    model_reset();
    repeat (2) @(posedge wb_clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_xcyc", x_cyc, 0);
    check("rst_mack", m_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout, 0);
    check("rst_xadr", x_adr, 0);
    wb_rst = 1'b0;
  endtask

  // One clock cycle: RAM response, sample at negedge, compare, advance the model.
  task automatic step();
    logic e_xcyc, e_xwe, forced;
    logic [3:0] e_xsel;
    logic [AW-1:0] e_xadr;
    logic [WIDTH-1:0] e_xdat;
    logic [N-1:0] e_ack, e_grant;
    logic [WIDTH*N-1:0] e_rdt;
    int w;
    e_xcyc = 0; e_xwe = 0; e_xsel = '0; e_xadr = '0; e_xdat = '0;
    e_ack = '0; e_grant = '0; e_rdt = '0; forced = 0;
    if (ph == 1) begin
      e_grant[own] = 1'b1;
      e_xcyc = m_cyc[own];
      e_xwe  = m_we[own];
      e_xsel = m_sel[own*4 +: 4];
      e_xadr = m_adr[own*AW +: AW];
      e_xdat = m_dat[own*WIDTH +: WIDTH];
    end
    x_rdt = $urandom;
    if (e_xcyc) begin
      x_ack = !ram_never && (ram_wait >= ram_lat);
      if (x_ack && !e_xwe) x_rdt = mem[e_xadr[5:2]];
    end else begin
      x_ack = (ph != 1) && ($urandom_range(0, 99) < stray_pct);
    end
    if (ph == 1) begin
      forced = e_xcyc && !x_ack && (age == TIMEOUT - 1);
      e_ack[own] = e_xcyc && (x_ack || forced);
      if (!forced) e_rdt[own*WIDTH +: WIDTH] = x_rdt;
    end
    @(negedge wb_clk);
    s_xcyc = x_cyc; s_xwe = x_we; s_xsel = x_sel; s_xadr = x_adr; s_xdat = x_dat;
    s_mack = m_ack; s_mrdt = m_rdt; s_grant = grant; s_busy = busy; s_timeout = timeout;
    check("x_cyc", s_xcyc, e_xcyc);
    check("x_we", s_xwe, e_xwe);
    check("x_sel", s_xsel, e_xsel);
    check("x_adr", s_xadr, e_xadr);
    check("x_dat", s_xdat, e_xdat);
    check("m_ack", s_mack, e_ack);
    check("m_rdt", s_mrdt, e_rdt);
    check("grant", s_grant, e_grant);
    check("busy", s_busy, ph != 0);
    check("timeout", s_timeout, forced);
    ack_seen = e_ack;
    // RAM stores what actually appears on the x bus
    if (e_xcyc && x_ack && s_xwe) begin
      for (int b = 0; b < 4; b++)
        if (s_xsel[b]) mem[s_xadr[5:2]][8*b +: 8] = s_xdat[8*b +: 8];
    end
    case (ph)
      0: begin
        w = pick(m_cyc, lst);
        if (w >= 0) begin
          ph = 1; own = w; age = 0; ram_wait = 0;
          if (!(PRIO && w == 0)) lst = w;
          ram_lat = $urandom_range(0, lat_max);
          ram_never = ($urandom_range(0, 99) < never_pct);
        end
      end
      1: begin
        if (!e_xcyc) ph = 0;
        else if (e_ack[own]) ph = 2;
        else begin age++; ram_wait++; end
      end
      default: ph = 0;
    endcase
    @(posedge wb_clk);
    #1;
  endtask

  task automatic collect_grants(input string tag, input int budget);
    logic [N-1:0] prev;
    prev = '0;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      step();
      if (s_grant != 0 && prev == 0) check(tag, s_grant, exp_q.pop_front());
      prev = s_grant;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, tcount, acks0;
    bit got, seen2;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // single requester read, 1-cycle RAM
    do_reset();
    mem[4] = 32'hDEADBEEF;
    set_req(1, 1, 0, 4'hF, 32'h10, 32'h0);
    step();
    check("t1_arb_lat", s_xcyc, 0);
    step();
    check("t1_xcyc", s_xcyc, 1);
    check("t1_ack", s_mack, 3'b010);
    check("t1_rdt", s_mrdt, 96'h00000000_DEADBEEF_00000000);
    step();
    check("t1_gap_xcyc", s_xcyc, 0);
    check("t1_gap_busy", s_busy, 1);
    m_cyc[1] = 1'b0;
    step();
    check("t1_idle", s_busy, 0);

    // all three requesting continuously from reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 4'hF, AW'(i * 16), 32'h0);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
    end
    if (PRIO) begin
      exp_q.delete();
      repeat (6) exp_q.push_back(3'b001);
    end
    collect_grants("t2_order", 40);

    // requester 2 writes while requester 0 reads the same word
    do_reset();
    lat_max = 1;
    mem[8] = 32'hAAAA5555;
    set_req(0, 1, 0, 4'hF, 32'h20, 32'h0);
    set_req(2, 1, 1, 4'b0011, 32'h20, 32'h00001234);
    seen2 = 0; acks0 = 0;
    for (int c = 0; c < 40 && acks0 < 2; c++) begin
      step();
      if (s_grant == 3'b100 && !seen2) begin
        seen2 = 1;
        check("t3_we", s_xwe, 1);
        check("t3_sel", s_xsel, 4'b0011);
        check("t3_adr", s_xadr, 32'h20);
        check("t3_dat", s_xdat, 32'h1234);
      end
      if (s_mack[0]) begin
        acks0++;
        check(acks0 == 1 ? "t3_rd_old" : "t3_rd_new", s_mrdt[31:0],
              acks0 == 1 ? 32'hAAAA5555 : 32'hAAAA1234);
      end
    end
    check("t3_seen_wr", seen2, 1);
    check("t3_two_reads", acks0, 2);

    // RAM never acks: forced completion on BUSY cycle TIMEOUT
    do_reset();
    never_pct = 100;
    set_req(1, 1, 0, 4'hF, 32'h4, 32'h0);
    set_req(2, 1, 0, 4'hF, 32'h8, 32'h0);
    n = 0; tcount = 0; got = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      step();
      if (s_grant != 0) n++;
      if (s_timeout) tcount++;
      if (s_mack != 0) begin
        got = 1;
        check("t4_cycle", n, TIMEOUT);
        check("t4_who", s_mack, 3'b010);
        check("t4_rdt0", s_mrdt, 0);
        check("t4_pulse", s_timeout, 1);
      end
    end
    check("t4_got", got, 1);
    never_pct = 0;
    step();
    check("t4_gap", {s_busy, s_grant}, 4'b1000);
    if (s_timeout) tcount++;
    step();
    check("t4_idle", {s_busy, s_grant}, 4'b0000);
    step();
    check("t4_next", s_grant, 3'b100);
    if (s_timeout) tcount++;
    check("t4_pulses", tcount, 1);

    // owner aborts mid-BUSY
    do_reset();
    never_pct = 100;
    set_req(1, 1, 0, 4'hF, 32'hC, 32'h0);
    repeat (3) step();
    m_cyc[1] = 1'b0;
    step();
    check("t5_abort_ack", s_mack, 0);
    check("t5_abort_xcyc", s_xcyc, 0);
    step();
    check("t5_abort_idle", {s_busy, s_grant}, 4'b0000);

    // reset asserted mid-BUSY
    do_reset();
    never_pct = 100;
    set_req(1, 1, 0, 4'hF, 32'hC, 32'h0);
    repeat (3) step();
    #2 wb_rst = 1'b1;
    #1;
    check("t5_rst_xcyc", x_cyc, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_ack", m_ack, 0);
    model_reset();
    never_pct = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 4'hF, AW'(i * 4), 32'h0);
    @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    step();
    step();
    check("t5_rst_next", s_grant, 3'b001);

    // requesters 0 and 1 always requesting
    do_reset();
    set_req(0, 1, 0, 4'hF, 32'h0, 32'h0);
    set_req(1, 1, 0, 4'hF, 32'h4, 32'h0);
    for (int r = 0; r < 6; r++) exp_q.push_back((PRIO || r % 2 == 0) ? 3'b001 : 3'b010);
    collect_grants("t6_prio", 40);

    // randomized soak against the reference model
    do_reset();
    lat_max = 3; never_pct = 3; stray_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i] && ack_seen[i]) m_cyc[i] = 1'b0;
        else if (m_cyc[i] && $urandom_range(0, 59) == 0) m_cyc[i] = 1'b0;
        if (!m_cyc[i] && $urandom_range(0, 99) < 40)
          set_req(i, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                  AW'($urandom_range(0, 15) * 4), $urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rr_arb.md
Name: ram_rr_arb

Overview:
- N-requester Wishbone-classic arbiter that shares the single-port data RAM. Typical requesters are the CPU dbus, the audio_engine DMA and a future LED/UART DMA.
- It generalises the fixed two-port RAM sharing to round-robin with a per-transaction timeout.
- It sits between the requesters and the RAM chip_select/sp_ram pair (port X).
- Read data and ack going back to requesters are zero when not owned, so they can be OR-combined onto the dbus.

Parameters:
N, 3, number of requesters (2..8); index 0 is normally the CPU dbus
WIDTH, 32, data width
AW, 32, address width
TIMEOUT, 64, cycles to wait for x_ack before force-completing (>=2)

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset, asynchronous, active-high
m_cyc  in  N  request/cycle per requester
m_we  in  N  write enable per requester
m_sel  in  4*N  byte selects, requester i at [4i+3:4i]
m_adr  in  AW*N  address, requester i at [AW*i+AW-1:AW*i]
m_dat  in  WIDTH*N  write data
m_ack  out  N  ack, owner only
m_rdt  out  WIDTH*N  read data, owner slice only, others 0
x_cyc  out  1  to RAM chip select
x_we  out  1  muxed
x_sel  out  4  muxed
x_adr  out  AW  muxed
x_dat  out  WIDTH  muxed
x_ack  in  1  from RAM chip select
x_rdt  in  WIDTH  from RAM
grant  out  N  one-hot current owner
busy  out  1  state != IDLE
timeout  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, wb_rst=1): state IDLE, grant=0, x_cyc=0, m_ack=0, timeout=0, last=N-1, wait counter=0. All x_* mux outputs are 0 while grant=0.
- States:
  - IDLE: if any m_cyc, pick winner w = first requester with cyc, scanning (last+1) mod N upward with wrap. Register grant=onehot(w) and last=w, clear counter, go to BUSY. Decision is made in the IDLE cycle; x_cyc rises the next cycle (1-cycle arbitration latency).
  - BUSY: x_cyc = m_cyc[w]; x_we/sel/adr/dat are combinational muxes of requester w. m_ack[w] = x_ack and m_rdt slice w = x_rdt (combinational pass-through, no added latency).
    - On x_ack: go to GAP.
    - If m_cyc[w] drops before ack (abort): go to IDLE, grant=0.
    - Counter increments each cycle without x_ack. On reaching TIMEOUT-1: drive m_ack[w]=1 with m_rdt=0 for one cycle, pulse timeout, go to GAP.
  - GAP: one dead cycle with grant=0 and x_cyc=0, so a requester holding cyc one cycle after ack is not re-served. Then go to IDLE.
- Throughput: a continuously requesting set gets one transaction per 3+RAM-latency cycles. Fairness: each requester waits at most N-1 transactions.
- Simultaneous requests: resolved purely by the rotating pointer. Requests arriving during BUSY/GAP wait, with no loss.
- An x_ack seen in IDLE or GAP (stray) is ignored: no m_ack is generated.
- Reset asserted mid-BUSY: outputs clear immediately. The pending transaction is dropped and its requester receives no ack.
- Counter width is clog2(TIMEOUT).

Optional Feature:
- Macro: RAM_RR_ARB_PRIORITY0_EN.
- Defined: requester 0 always wins when its m_cyc is high in IDLE. Others are round-robin among themselves, and last is not updated by requester-0 grants.
- Undefined: pure round-robin across all N as above.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state enum {IDLE, BUSY, GAP};
  - localparams for the default N/WIDTH/TIMEOUT;
  - function onehot_to_index.
- One sub-module, rr_pick: combinational rotating priority encoder. Inputs are the req vector and the last index; outputs are the winner index and a valid flag. It takes a PRIORITY0 parameter driven from the macro.

Test Plan:
- Single requester 1 reads adr 0x10 (RAM returns 0xDEADBEEF, 1-cycle ack) -> x_cyc rises 1 cycle after m_cyc[1], m_ack[1] with m_rdt[63:32]=0xDEADBEEF, m_rdt of others 0, GAP, then idle.
- All 3 requesters assert cyc continuously from reset -> grant order 0,1,2,0,1,2. No requester is served twice before the others are served once.
- Requester 2 write sel=4'b0011 adr 0x20 dat 0x1234 while 0 reads -> x_we/x_sel/x_dat reflect only the owner. RAM sees the 0x1234 write with sel 0011 during requester 2's grant.
- RAM never acks, TIMEOUT=64 -> m_ack[w] pulses on cycle 64 of BUSY with rdt 0, timeout pulses once, next requester is granted after GAP.
- Owner drops cyc mid-BUSY, then reset is asserted mid-BUSY in a separate run -> return to IDLE with no ack. With reset: x_cyc/grant/m_ack go 0 immediately and the next grant after release goes to requester 0.
- With RAM_RR_ARB_PRIORITY0_EN, requesters 0 and 1 always requesting -> requester 0 granted every transaction and requester 1 starves. Without the macro they alternate 0,1,0,1.
